mod_counter: RTL and testbench

//   Parametrised up/down modulo counter; next generation of the fixed 4-bit wrap counter.

---
 rtl/counter_pkg.sv | 22 ++
 rtl/counter_prescaler.sv | 37 +++
 rtl/mod_counter.sv | 101 ++++++++++
 tb/tb_mod_counter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared types and helpers for the mod_counter family
//   dir_e              count direction (DIR_UP=0, DIR_DOWN=1)
//   mode_e             terminal behaviour (MODE_WRAP=0, MODE_SAT=1)
//   counter_prescale_w width of a prescaler that counts 0..PRESCALE-1 (at least 1 bit)
package counter_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    // $clog2(1) is 0, so a single-cycle prescaler still gets one bit
    function automatic int counter_prescale_w(input int prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// counter_prescaler: divides enabled cycles so one step fires every PRESCALE en cycles
//   clk       in  clock
//   reset     in  asynchronous active-high reset
//   en        in  count enable; the prescaler only advances on en cycles
//   restart   in  synchronous return to 0 (clear or load on the counter)
//   step_tick out high on the en cycle where the prescaler sits at PRESCALE-1
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic step_tick
);

    localparam int PW = counter_prescale_w(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    assign step_tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = restart   ? '0 :
                !en       ? cnt_q :
                step_tick ? '0 : cnt_q + PW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mod_counter.sv
// mod_counter: parametrised up/down modulo counter with runtime modulus, wrap/saturate mode,
//   terminal-count and wrap-event outputs. Optional prescaler under COUNTER_PRESCALE_EN.
//   clk      in  clock
//   reset    in  asynchronous active-high reset
//   clear    in  synchronous clear to 0 (beats load and en)
//   load     in  synchronous load of min(load_val, max_val) (beats en)
//   load_val in  load value
//   en       in  count enable
//   dir      in  0 = up, 1 = down (counter_pkg::dir_e)
//   mode     in  0 = wrap, 1 = saturate (counter_pkg::mode_e)
//   max_val  in  inclusive upper bound of the count range
//   count    out registered count
//   at_term  out combinational terminal count (up: count==max_val, down: count==0)
//   wrap     out registered one-cycle pulse on a wrapping step
module mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] count,
    output logic             at_term,
    output logic             wrap
);

    if (WIDTH < 1 || PRESCALE < 1) begin : g_bad_params
        $error("mod_counter: WIDTH and PRESCALE must be >= 1");
    end

    dir_e             dir_s;
    mode_e            mode_s;
    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             step_tick;

    assign dir_s  = dir_e'(dir);
    assign mode_s = mode_e'(mode);

`ifdef COUNTER_PRESCALE_EN
    counter_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .restart  (clear | load),
        .step_tick(step_tick)
    );
`else
    assign step_tick = en;
`endif

    // Every +1/-1 is guarded by an explicit compare so WIDTH-bit overflow never happens
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = (load_val > max_val) ? max_val : load_val;
        end else if (step_tick) begin
            if (dir_s == DIR_UP) begin
                if (count_q > max_val)       count_d = '0;
                else if (count_q == max_val) begin
                    count_d = (mode_s == MODE_WRAP) ? '0 : count_q;
                    wrap_d  = (mode_s == MODE_WRAP);
                end else                     count_d = count_q + WIDTH'(1);
            end else begin
                if (count_q > max_val)       count_d = max_val;
                else if (count_q == '0) begin
                    count_d = (mode_s == MODE_WRAP) ? max_val : count_q;
                    wrap_d  = (mode_s == MODE_WRAP);
                end else                     count_d = count_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count   = count_q;
    assign wrap    = wrap_q;
    assign at_term = (dir_s == DIR_DOWN) ? (count_q == '0) : (count_q == max_val);

endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: directed scenarios plus random stimulus checked against an integer reference model
module tb_mod_counter;

    localparam int W  = 4;
    localparam int PS = 3;
`ifdef COUNTER_PRESCALE_EN
    localparam int P = PS;
`else
    localparam int P = 1;
`endif

    logic         clk = 1'b0;
    logic         reset, clear, load, en, dir, mode;
    logic [W-1:0] load_val, max_val, count;
    logic         at_term, wrap;

    int m_cnt, m_wrap, m_ps;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mod_counter #(
        .WIDTH   (W),
        .PRESCALE(PS)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .load    (load),
        .load_val(load_val),
        .en      (en),
        .dir     (dir),
        .mode    (mode),
        .max_val (max_val),
        .count   (count),
        .at_term (at_term),
        .wrap    (wrap)
    );

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Reference: counter value is a plain integer in 0..max_val, moved one step at a time
    task automatic model_edge();
        int mx;
        mx = int'(max_val);
        m_wrap = 0;
        if (reset) begin
            m_cnt = 0;
            m_ps  = 0;
        end else if (clear) begin
            m_cnt = 0;
            m_ps  = 0;
        end else if (load) begin
            m_cnt = (int'(load_val) > mx) ? mx : int'(load_val);
            m_ps  = 0;
        end else if (en) begin
            if (m_ps < P - 1) m_ps++;
            else begin
                m_ps = 0;
                if (!dir) begin
                    if (m_cnt > mx) m_cnt = 0;
                    else if (m_cnt < mx) m_cnt++;
                    else if (!mode) begin m_cnt = 0; m_wrap = 1; end
                end else begin
                    if (m_cnt > mx) m_cnt = mx;
                    else if (m_cnt > 0) m_cnt--;
                    else if (!mode) begin m_cnt = mx; m_wrap = 1; end
                end
            end
        end
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        chk({tag, ".count"}, int'(count), m_cnt);
        chk({tag, ".wrap"}, int'(wrap), m_wrap);
        chk({tag, ".at_term"}, int'(at_term), dir ? int'(m_cnt == 0) : int'(m_cnt == int'(max_val)));
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; load = 1'b0; en = 1'b0; dir = 1'b0; mode = 1'b0;
        load_val = '0; max_val = 4'd15;
        m_cnt = 0; m_wrap = 0; m_ps = 0;
        #12;
        reset = 1'b0;
        #1;
        chk("reset.count", int'(count), 0);
        chk("reset.wrap", int'(wrap), 0);
        chk("reset.at_term", int'(at_term), 0);

        // up/wrap through the full 4-bit range
        en = 1'b1;
        for (int i = 1; i <= 16 * P; i++) begin
            tick("t1");
            if (i == 15 * P) chk("t1.at15", int'(count), 15);
        end
        chk("t1.wrapped", int'(count), 0);
        chk("t1.wrap_pulse", int'(wrap), 1);

        // down/wrap with max_val=9 starting from 0
        max_val = 4'd9; dir = 1'b1; clear = 1'b1;
        tick("t2clr");
        clear = 1'b0;
        for (int i = 1; i <= 11 * P; i++) tick("t2");
        chk("t2.rewrap", int'(count), 9);
        chk("t2.wrap_pulse", int'(wrap), 1);

        // up/saturate from 7
        load = 1'b1; load_val = 4'd7;
        tick("t3ld");
        load = 1'b0; dir = 1'b0; mode = 1'b1;
        for (int i = 1; i <= 4 * P; i++) tick("t3");
        chk("t3.sat", int'(count), 9);
        chk("t3.nowrap", int'(wrap), 0);

        // load clamps to max_val; clear beats load
        load = 1'b1; load_val = 4'd12;
        tick("t4ld");
        chk("t4.clamp", int'(count), 9);
        clear = 1'b1;
        tick("t4clr");
        chk("t4.clear_wins", int'(count), 0);
        clear = 1'b0; load = 1'b0;

        // asynchronous reset mid-cycle while counting at 6
        load = 1'b1; load_val = 4'd6; mode = 1'b0;
        tick("t5ld");
        load = 1'b0;
        #3;
        reset = 1'b1;
        m_cnt = 0; m_wrap = 0; m_ps = 0;
        #1;
        chk("t5.async_count", int'(count), 0);
        chk("t5.async_wrap", int'(wrap), 0);
        tick("t5hold");
        tick("t5hold");
        #2;
        reset = 1'b0;

        // randomized: occasional runtime max_val changes (including 0 and below count)
        for (int i = 0; i < 600; i++) begin
            clear = ($urandom_range(0, 15) == 0);
            load  = ($urandom_range(0, 9) == 0);
            en    = ($urandom_range(0, 3) != 0);
            dir   = ($urandom_range(0, 7) == 0) ? ~dir : dir;
            mode  = ($urandom_range(0, 15) == 0) ? ~mode : mode;
            load_val = W'($urandom);
            if ($urandom_range(0, 19) == 0) max_val = W'($urandom_range(0, 15));
            tick("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
